// File: rtl/ex_wb_flag_stage.sv
// rtl/ex_wb_flag_stage.sv - EX/WB latch with Z/N flag register, branch resolve and wrong-path squash
// Optional FLAG_RECOMPUTE_EN: derive Z/N from in_result instead of in_zero/in_neg.
module ex_wb_flag_stage #(
  parameter int DATA_W       = 32,
  parameter int RD_W         = 6,
  parameter int SHADOW_SLOTS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_stall,
  input  logic              in_flush,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_zero,
  input  logic              in_neg,
  input  logic [2:0]        in_ctrl_aluop,
  input  logic              in_ctrl_regwrite,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [1:0]        in_ctrl_branch,
  input  logic [DATA_W-1:0] in_target,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_regwrite,
  output logic              out_flag_z,
  output logic              out_flag_n,
  output logic              out_take_branch,
  output logic [DATA_W-1:0] out_branch_target
);

  localparam logic [2:0] ALUOP_NOP  = 3'b011;
  localparam logic [2:0] SHADOW_CNT = 3'(SHADOW_SLOTS);
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_SQUASH  = 1'b1;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              regwrite_q, regwrite_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_n_q, flag_n_d;
  logic              take_q, take_d;
  logic [DATA_W-1:0] target_q, target_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [0:0]        state;
  logic              z_src, n_src;
  logic              ev;
  logic              taken;

`ifdef FLAG_RECOMPUTE_EN
  assign z_src = (in_result == '0);
  assign n_src = in_result[DATA_W-1];
`else
  assign z_src = in_zero;
  assign n_src = in_neg;
`endif

  assign state = (cnt_q != 3'd0) ? ST_SQUASH : ST_IDLE;
  assign ev    = in_valid & ~in_flush & (state == ST_IDLE);
  // Branch condition uses the flags left by the previous instruction.
  assign taken = ((in_ctrl_branch == 2'b01) & flag_z_q) |
                 ((in_ctrl_branch == 2'b10) & flag_n_q) |
                 (in_ctrl_branch == 2'b11);

  always_comb begin
    valid_d    = valid_q;
    result_d   = result_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    flag_z_d   = flag_z_q;
    flag_n_d   = flag_n_q;
    take_d     = 1'b0;
    target_d   = target_q;
    cnt_d      = cnt_q;
    if (!in_stall) begin
      result_d   = in_result;
      rd_d       = in_rd;
      valid_d    = ev;
      regwrite_d = in_ctrl_regwrite & ev;
      if (in_flush) begin
        cnt_d = 3'd0;
      end else if (state == ST_SQUASH) begin
        if (in_valid) cnt_d = cnt_q - 3'd1;
      end else if (in_valid) begin
        if (in_ctrl_aluop != ALUOP_NOP) begin
          flag_z_d = z_src;
          flag_n_d = n_src;
        end
        if (taken) begin
          take_d   = 1'b1;
          target_d = in_target;
          cnt_d    = SHADOW_CNT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      result_q   <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      flag_z_q   <= 1'b0;
      flag_n_q   <= 1'b0;
      take_q     <= 1'b0;
      target_q   <= '0;
      cnt_q      <= 3'd0;
    end else begin
      valid_q    <= valid_d;
      result_q   <= result_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      flag_z_q   <= flag_z_d;
      flag_n_q   <= flag_n_d;
      take_q     <= take_d;
      target_q   <= target_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid         = valid_q;
  assign out_result        = result_q;
  assign out_rd            = rd_q;
  assign out_regwrite      = regwrite_q & valid_q;
  assign out_flag_z        = flag_z_q;
  assign out_flag_n        = flag_n_q;
  assign out_take_branch   = take_q & ~in_stall;
  assign out_branch_target = target_q;

endmodule
